// File: rtl/cache_port_arbiter.sv
// Two-port arbiter/sequencer holding one request on a blocking cache port, with per-port access/miss counters.
// Define CACHE_ARB_RR_EN for round-robin arbitration; by default port 0 has fixed priority.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]              req_read,
  input  logic [1:0]              req_write,
  input  logic [2*DATA_WIDTH-1:0] req_din,
  output logic [1:0]              req_ready,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_dout,
  output logic                    resp_hit,
  output logic                    cache_is_input_valid,
  output logic [ADDR_WIDTH-1:0]   cache_addr,
  output logic                    cache_mem_read,
  output logic                    cache_mem_write,
  output logic [DATA_WIDTH-1:0]   cache_din,
  input  logic                    cache_is_ready,
  input  logic                    cache_is_output_valid,
  input  logic [DATA_WIDTH-1:0]   cache_dout,
  output logic [2*CNT_WIDTH-1:0]  acc_cnt,
  output logic [2*CNT_WIDTH-1:0]  miss_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_first;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_read;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_cache_vld;
  logic [1:0]            r_resp_vld;
  logic [DATA_WIDTH-1:0] r_resp_dout;
  logic                  r_resp_hit;
  logic [CNT_WIDTH-1:0]  r_acc_cnt  [2];
  logic [CNT_WIDTH-1:0]  r_miss_cnt [2];

  logic                  w_accept;
  logic                  w_win;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_din;

`ifdef CACHE_ARB_RR_EN
  logic r_last_grant;
  // On a tie the port that did not win last time goes next.
  assign w_win = (&req_valid) ? ~r_last_grant : ~req_valid[0];
`else
  assign w_win = ~req_valid[0];
`endif

  // Accept is combinational so the requester sees req_ready in the accept cycle itself.
  assign w_accept   = reset && (r_state == IDLE) && cache_is_ready && (|req_valid);
  assign req_ready  = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign w_sel_addr = w_win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign w_sel_din  = w_win ? req_din[2*DATA_WIDTH-1:DATA_WIDTH]  : req_din[DATA_WIDTH-1:0];

  assign resp_valid           = r_resp_vld;
  assign resp_dout            = r_resp_dout;
  assign resp_hit             = r_resp_hit;
  assign cache_is_input_valid = r_cache_vld;
  assign cache_addr           = r_addr;
  assign cache_mem_read       = r_read;
  assign cache_mem_write      = r_write;
  assign cache_din            = r_din;
  assign acc_cnt              = {r_acc_cnt[1], r_acc_cnt[0]};
  assign miss_cnt             = {r_miss_cnt[1], r_miss_cnt[0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_first       <= 1'b0;
      r_addr        <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_din         <= '0;
      r_cache_vld   <= 1'b0;
      r_resp_vld    <= 2'b00;
      r_resp_dout   <= '0;
      r_resp_hit    <= 1'b0;
      r_acc_cnt[0]  <= '0;
      r_acc_cnt[1]  <= '0;
      r_miss_cnt[0] <= '0;
      r_miss_cnt[1] <= '0;
`ifdef CACHE_ARB_RR_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      r_cache_vld <= 1'b0;
      r_resp_vld  <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner     <= w_win;
            r_addr      <= w_sel_addr;
            r_read      <= req_read[w_win];
            r_write     <= req_write[w_win];
            r_din       <= w_sel_din;
            r_cache_vld <= 1'b1;
            if (r_acc_cnt[w_win] != CNT_MAX)
              r_acc_cnt[w_win] <= r_acc_cnt[w_win] + CNT_ONE;
`ifdef CACHE_ARB_RR_EN
            r_last_grant <= w_win;
`endif
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_first <= 1'b1;
          r_state <= WAIT;
        end
        WAIT: begin
          // Completion in the first WAIT cycle means the cache needed no miss handling.
          if (cache_is_output_valid) begin
            r_resp_dout <= cache_dout;
            r_resp_hit  <= r_first;
            r_resp_vld  <= r_owner ? 2'b10 : 2'b01;
            if (!r_first && (r_miss_cnt[r_owner] != CNT_MAX))
              r_miss_cnt[r_owner] <= r_miss_cnt[r_owner] + CNT_ONE;
            r_state <= RESP;
          end else begin
            r_first <= 1'b0;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: vector table of single transactions, arbitration/saturation/reset sequences, response scoreboard.
module tb_cache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid;
  logic [2*AW-1:0] req_addr;
  logic [1:0]      req_read;
  logic [1:0]      req_write;
  logic [2*DW-1:0] req_din;
  logic [1:0]      req_ready;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_dout;
  logic            resp_hit;
  logic            cache_is_input_valid;
  logic [AW-1:0]   cache_addr;
  logic            cache_mem_read;
  logic            cache_mem_write;
  logic [DW-1:0]   cache_din;
  logic            cache_is_ready;
  logic            cache_is_output_valid;
  logic [DW-1:0]   cache_dout;
  logic [2*CW-1:0] acc_cnt;
  logic [2*CW-1:0] miss_cnt;

  cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_addr              (req_addr),
    .req_read              (req_read),
    .req_write             (req_write),
    .req_din               (req_din),
    .req_ready             (req_ready),
    .resp_valid            (resp_valid),
    .resp_dout             (resp_dout),
    .resp_hit              (resp_hit),
    .cache_is_input_valid  (cache_is_input_valid),
    .cache_addr            (cache_addr),
    .cache_mem_read        (cache_mem_read),
    .cache_mem_write       (cache_mem_write),
    .cache_din             (cache_din),
    .cache_is_ready        (cache_is_ready),
    .cache_is_output_valid (cache_is_output_valid),
    .cache_dout            (cache_dout),
    .acc_cnt               (acc_cnt),
    .miss_cnt              (miss_cnt)
  );

  typedef struct {
    logic [1:0]    vld;
    logic [DW-1:0] dout;
    logic          hit;
  } exp_t;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          rd;
    logic [DW-1:0] din;
    int            lat;
    logic [DW-1:0] dout;
    int            rdy_dly;
  } vec_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            tb_lat = 1;
  logic [DW-1:0] tb_dout = '0;
  logic [CW-1:0] exp_acc [2];
  logic [CW-1:0] exp_miss[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Cache model: completion arrives tb_lat cycles after the strobe cycle.
  initial begin
    int cd;
    cd = 0;
    cache_is_output_valid = 1'b0;
    cache_dout = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) cd = 0;
      else if (cache_is_input_valid === 1'b1) cd = tb_lat;
      @(posedge clk);
      #1;
      cache_is_output_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cache_is_output_valid = 1'b1;
          cache_dout = tb_dout;
        end
      end
    end
  end

  // Response monitor and protocol checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (req_ready != 2'b00) chk("ready_needs_cache_ready", cache_is_ready, 1);
        if (resp_valid != 2'b00) begin
          chk("resp_ready_exclusive", req_ready, 0);
          if (sb.size() == 0) begin
            chk("unexpected_resp", resp_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("resp_valid", resp_valid, e.vld);
            chk("resp_dout", resp_dout, e.dout);
            chk("resp_hit", resp_hit, e.hit);
          end
        end
      end
    end
  end

  task automatic chk_counters(input string tag);
    chk({tag, "_acc_cnt"},  acc_cnt,  {exp_acc[1], exp_acc[0]});
    chk({tag, "_miss_cnt"}, miss_cnt, {exp_miss[1], exp_miss[0]});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {req_ready, resp_valid, resp_hit, cache_is_input_valid, cache_mem_read, cache_mem_write}, 0);
    chk({tag, "_resp_dout"}, resp_dout, 0);
    chk({tag, "_cache_addr"}, cache_addr, 0);
    chk({tag, "_cache_din"}, cache_din, 0);
    chk({tag, "_counters"}, {acc_cnt, miss_cnt}, 0);
  endtask

  task automatic run_txn(input vec_t v);
    int            waits;
    int            n;
    logic          hold_ok;
    logic          early;
    logic [1:0]    onehot;
    exp_t          e;
    onehot = (v.port == 1) ? 2'b10 : 2'b01;
    tb_lat = v.lat;
    tb_dout = v.dout;
    req_addr  = (v.port == 1) ? {v.addr, ~v.addr} : {~v.addr, v.addr};
    req_din   = (v.port == 1) ? {v.din, ~v.din} : {~v.din, v.din};
    req_read  = {v.rd, v.rd};
    req_write = {~v.rd, ~v.rd};
    req_valid = onehot;
    if (v.rdy_dly > 0) begin
      early = 1'b0;
      cache_is_ready = 1'b0;
      repeat (v.rdy_dly) begin
        @(negedge clk);
        if (req_ready != 2'b00) early = 1'b1;
      end
      @(posedge clk);
      #1;
      cache_is_ready = 1'b1;
      chk("no_ready_while_cache_busy", early, 0);
    end
    waits = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_grant", req_ready, onehot);
    if (req_ready == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    if (v.rdy_dly > 0) chk("accept_on_ready_rise", waits, 0);
    e.vld = onehot;
    e.dout = v.dout;
    e.hit = (v.lat == 1);
    sb.push_back(e);
    exp_acc[v.port] = sat_inc(exp_acc[v.port]);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("strobe", cache_is_input_valid, 1);
    chk("cache_addr", cache_addr, v.addr);
    chk("cache_rw", {cache_mem_read, cache_mem_write}, {v.rd, ~v.rd});
    chk("cache_din", cache_din, v.din);
    n = 1;
    hold_ok = 1'b1;
    while (resp_valid == 2'b00 && n < v.lat + 20) begin
      if (cache_addr !== v.addr || cache_din !== v.din || cache_mem_read !== v.rd ||
          cache_mem_write !== ~v.rd || (n > 1 && cache_is_input_valid !== 1'b0))
        hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("resp_latency", n, v.lat + 2);
    chk("hold_stable", hold_ok, 1);
    if (v.lat != 1) exp_miss[v.port] = sat_inc(exp_miss[v.port]);
    chk_counters("txn");
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   waits;
    int   exp_port;
    exp_t e;

    tbl[0] = '{0, 32'h0000_0100, 1'b1, 32'h0000_0000, 1, 32'hDEAD_BEEF, 0};
    tbl[1] = '{1, 32'h0000_0200, 1'b0, 32'h0000_1234, 8, 32'h0000_0000, 0};
    tbl[2] = '{0, 32'h0000_0040, 1'b1, 32'h0000_0000, 1, 32'h0BAD_CAFE, 5};
    tbl[3] = '{0, 32'hFFFF_FFFC, 1'b0, 32'hA5A5_A5A5, 1, 32'h0000_0000, 0};
    tbl[4] = '{1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 32'h0000_0001, 0};
    tbl[5] = '{0, 32'h8000_0000, 1'b1, 32'h0000_0000, 3, 32'h1357_9BDF, 0};
    tbl[6] = '{1, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 2, 32'hFFFF_FFFF, 0};

    exp_acc[0] = '0; exp_acc[1] = '0; exp_miss[0] = '0; exp_miss[1] = '0;
    reset = 1'b0;
    req_valid = 2'b00;
    req_addr = '0;
    req_read = 2'b00;
    req_write = 2'b00;
    req_din = '0;
    cache_is_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Both ports requesting back to back; last table grant went to port 1.
    tb_lat = 1;
    tb_dout = 32'hC0FF_EE00;
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    req_din   = '0;
    req_read  = 2'b11;
    req_write = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
      exp_port = k % 2;
`else
      exp_port = 0;
`endif
      waits = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && waits < 20) begin
        @(negedge clk);
        waits++;
      end
      chk("grant_order", req_ready, (exp_port == 1) ? 2'b10 : 2'b01);
      e.vld = (exp_port == 1) ? 2'b10 : 2'b01;
      e.dout = 32'hC0FF_EE00;
      e.hit = 1'b1;
      sb.push_back(e);
      exp_acc[exp_port] = sat_inc(exp_acc[exp_port]);
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    waits = 0;
    while (sb.size() != 0 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("arb_drain", sb.size(), 0);
    chk_counters("arb");
    @(posedge clk);
    #1;

    // Drive port 0's access counter up to one below saturation, then past it.
    v = '{0, 32'h0000_0080, 1'b1, 32'h0000_0000, 1, 32'h0BAD_F00D, 0};
    while (exp_acc[0] < CW'(14)) run_txn(v);
    for (int k = 0; k < 3; k++) begin
      run_txn(v);
      chk("acc_sat_p0", acc_cnt[CW-1:0], {CW{1'b1}});
    end

    // Reset while port 1's request waits on a slow cache.
    tb_lat = 8;
    tb_dout = 32'h5555_AAAA;
    req_addr  = {32'h0000_0300, 32'h0000_0000};
    req_read  = 2'b10;
    req_write = 2'b00;
    req_valid = 2'b10;
    waits = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("rst_txn_accept", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    sb.delete();
    exp_acc[0] = '0; exp_acc[1] = '0; exp_miss[0] = '0; exp_miss[1] = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_quiet", {resp_valid, cache_is_input_valid}, 0);
    @(posedge clk);
    #1;
    v = '{0, 32'h0000_0104, 1'b1, 32'h0000_0000, 1, 32'h2468_ACE0, 0};
    run_txn(v);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
